spi_slave_receiver: RTL and testbench
=====================================

Name: spi_slave_receiver

Overview:
- SPI slave endpoint; sits directly downstream of the SPI master controller on the serial link.
- Consumes the master's sclk/mosi/ss and drives miso back.
- Oversamples the serial inputs with the system clock and delivers each received word as a one-cycle rx_valid pulse.
- Accepts a reply word through a ready/load handshake; the reply is shifted out on the next frame.

Parameters:
- DATA_W, 8, bits per SPI word; legal range 4..16.
- SYNC_STAGES, 2, flip-flops in each input synchronizer (sclk, mosi, ss); minimum 2.
- DEFAULT_TX, 0, word shifted out when no reply word has been loaded.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- sclk  input  1  serial clock from master; idles low (mode 0).
- mosi  input  1  serial data from master; MSB first.
- ss  input  1  slave select from master; active low.
- miso  output  1  serial data to master; MSB first.
- rx_data  output  DATA_W  last complete received word.
- rx_valid  output  1  one-cycle pulse when rx_data updates.
- tx_data  input  DATA_W  reply word.
- tx_load  input  1  writes tx_data into the reply buffer; honoured only while tx_ready=1.
- tx_ready  output  1  reply buffer empty.
- busy  output  1  high while a frame is in progress.
- frame_err  output  1  one-cycle pulse on an aborted (partial) frame.

Behaviour:
- Reset: all of the following are forced while reset=0, independent of clk.
  - miso=0, rx_data=0, rx_valid=0, tx_ready=1, busy=0, frame_err=0.
  - Synchronizers: ss stages preset to 1; sclk and mosi stages cleared to 0.
  - Bit counter 0; state IDLE.
- Synchronization: sclk, mosi and ss each pass through SYNC_STAGES flops, giving equal latency. Edges are detected on the synchronized signals by comparing against a one-flop delayed copy.
- Timing requirement on the master: sclk high and low phases each ≥ 2 clk periods; mosi stable across the sclk rising edge. Faster sclk is unsupported and need not be detected.
- State machine:
  - IDLE:
    - On ss falling edge: load the shifter from the reply buffer if it is full, else from DEFAULT_TX.
    - Then: tx_ready=1 (buffer marked empty), miso=shifter MSB, bit_cnt=0, busy=1, go to SHIFT.
  - SHIFT, on sclk rising edge:
    - rx shift register <= {rx_shift[DATA_W-2:0], mosi_sync}; bit_cnt += 1.
    - When bit_cnt reaches DATA_W, in the cycle after the edge:
      - rx_data <= completed word; rx_valid=1 for exactly 1 cycle; bit_cnt=0.
      - Shifter reloads from the buffer or DEFAULT_TX, same rule as frame start (back-to-back words within one ss-low period).
  - SHIFT, on sclk falling edge: tx shifter shifts left; miso <= new MSB. A falling edge after the final bit of a word drives the MSB of the reloaded word.
  - SHIFT, on ss rising edge: busy=0; go to IDLE.
    - If bit_cnt≠0: frame_err pulses 1 cycle, partial word discarded, rx_valid not asserted.
    - If bit_cnt=0: frame ends cleanly.
- miso holds its last value in IDLE; it is not tri-stated.
- Simultaneous events:
  - ss rising in the same cycle as an sclk edge: the ss rise wins and the sclk edge is ignored.
  - tx_load in the same cycle as a shifter reload that empties the buffer: the reload takes the old buffer contents, and the new word is written and sets tx_ready=0. tx_ready is therefore computed after the reload.
- tx_load while tx_ready=0 is ignored; the buffer is unchanged.
- Latency: rx_valid asserts SYNC_STAGES+2 clk cycles after the last sclk rising edge at the pin.
- Reset mid-frame: immediate return to reset values; any partial word is lost, with no frame_err.

Optional Feature:
- Macro: SPI_SLAVE_OVERRUN_EN.
- Defined:
  - Adds input rx_ack and output rx_overrun (reset 0).
  - A word is pending from rx_valid until rx_ack=1.
  - Completing a new word while one is still pending sets rx_overrun sticky high. rx_data is still overwritten with the newer word.
  - rx_overrun clears only on reset or when rx_ack=1 with no word completing in that same cycle.
- Undefined: no rx_ack/rx_overrun ports; rx_data is overwritten silently.

Test Plan:
- Reset: reset=0 mid-idle -> every output at its reset value asynchronously; tx_ready=1.
- Single frame:
  - Stimulus: tx_load with 0x3C, then the master sends 0xA5 (sclk half-period 4 clk).
  - Required: rx_data=0xA5 with a single rx_valid pulse; miso bit sequence 0,0,1,1,1,1,0,0; tx_ready=1 again from frame start.
- No reply loaded: frame sending 0x5A without any tx_load -> miso carries DEFAULT_TX (0x00); rx_data=0x5A.
- Back-to-back: two words 0x01, 0xFF under one ss-low period -> two rx_valid pulses, rx_data 0x01 then 0xFF, busy continuously 1.
- Abort: ss raised after 5 sclk rising edges -> frame_err one pulse, no rx_valid, rx_data unchanged, busy=0.
- Overrun (SPI_SLAVE_OVERRUN_EN): two words with no rx_ack -> rx_overrun=1 after the second; rx_ack clears it.

Source files
------------

// File: rtl/spi_slave_receiver.sv
// spi_slave_receiver: mode-0 SPI slave that oversamples sclk/mosi/ss and has a one-word reply buffer.
// Define SPI_SLAVE_OVERRUN_EN to add rx_ack/rx_overrun tracking of unacknowledged words.
module spi_slave_receiver #(
  parameter int DATA_W = 8,
  parameter int SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0] DEFAULT_TX = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sclk,
  input  logic              mosi,
  input  logic              ss,
  output logic              miso,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_load,
  output logic              tx_ready,
  output logic              busy,
  output logic              frame_err
`ifdef SPI_SLAVE_OVERRUN_EN
  ,
  input  logic              rx_ack,
  output logic              rx_overrun
`endif
);
  localparam int CW = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] LAST = CW'(DATA_W);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state, state_next;
  logic [SYNC_STAGES-1:0] sclk_s, mosi_s, ss_s;
  logic sclk_d, ss_d;
  logic sclk_rise, sclk_fall, ss_rise, ss_fall;
  logic [CW-1:0] bit_cnt;
  logic [DATA_W-1:0] rx_shift, tx_shift, tx_buf, reload_word;
  logic tx_full, fresh;
  logic start, done, stop, abort, reload, shift_in, shift_out, accept;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      sclk_s <= '0;
      mosi_s <= '0;
      ss_s   <= '1;
      sclk_d <= 1'b0;
      ss_d   <= 1'b1;
    end else begin
      sclk_s <= {sclk_s[SYNC_STAGES-2:0], sclk};
      mosi_s <= {mosi_s[SYNC_STAGES-2:0], mosi};
      ss_s   <= {ss_s[SYNC_STAGES-2:0], ss};
      sclk_d <= sclk_s[SYNC_STAGES-1];
      ss_d   <= ss_s[SYNC_STAGES-1];
    end
  assign sclk_rise = sclk_s[SYNC_STAGES-1] & ~sclk_d;
  assign sclk_fall = ~sclk_s[SYNC_STAGES-1] & sclk_d;
  assign ss_rise   = ss_s[SYNC_STAGES-1] & ~ss_d;
  assign ss_fall   = ~ss_s[SYNC_STAGES-1] & ss_d;
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_next;
  // A completed word still counts if ss rises in the same cycle; an ss rise otherwise masks sclk edges.
  always_comb begin
    start      = (state == IDLE) && ss_fall;
    done       = (state == SHIFT) && (bit_cnt == LAST);
    stop       = (state == SHIFT) && ss_rise;
    abort      = stop && (bit_cnt != '0) && !done;
    reload     = start || (done && !stop);
    shift_in   = (state == SHIFT) && !stop && !done && sclk_rise;
    shift_out  = (state == SHIFT) && !stop && sclk_fall;
    state_next = start ? SHIFT : stop ? IDLE : state;
  end
  assign reload_word = tx_full ? tx_buf : DEFAULT_TX;
  assign accept      = tx_load && (!tx_full || reload);
  assign tx_ready    = !tx_full;
  assign busy        = (state == SHIFT);
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      bit_cnt   <= '0;
      rx_shift  <= '0;
      tx_shift  <= '0;
      tx_buf    <= '0;
      tx_full   <= 1'b0;
      fresh     <= 1'b0;
      miso      <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_valid  <= done;
      frame_err <= abort;
      if (done) rx_data <= rx_shift;
      if (start || done || stop) bit_cnt <= '0;
      else if (shift_in) begin
        bit_cnt  <= bit_cnt + 1'b1;
        rx_shift <= {rx_shift[DATA_W-2:0], mosi_s[SYNC_STAGES-1]};
      end
      if (reload) tx_shift <= reload_word;
      else if (shift_out && !fresh) tx_shift <= tx_shift << 1;
      // A mid-frame reload is presented on miso at the next falling edge, not immediately.
      if (start) miso <= reload_word[DATA_W-1];
      else if (shift_out) miso <= fresh ? tx_shift[DATA_W-1] : tx_shift[DATA_W-2];
      fresh   <= (done && !stop) || (fresh && !shift_out && !start);
      tx_full <= accept || (tx_full && !reload);
      if (accept) tx_buf <= tx_data;
    end
`ifdef SPI_SLAVE_OVERRUN_EN
  logic pending;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      pending    <= 1'b0;
      rx_overrun <= 1'b0;
    end else begin
      pending    <= done ? 1'b1 : rx_ack ? 1'b0 : pending;
      rx_overrun <= (done && pending) ? 1'b1 : (rx_ack && !done) ? 1'b0 : rx_overrun;
    end
`endif
endmodule

// File: tb/tb_spi_slave_receiver.sv
// tb_spi_slave_receiver: directed frames with hand-computed words for spi_slave_receiver.
module tb_spi_slave_receiver;
  logic clk = 1'b0, reset = 1'b0, sclk = 1'b0, mosi = 1'b0, ss = 1'b1;
  logic [7:0] tx_data = '0;
  logic tx_load = 1'b0;
  logic miso, rx_valid, tx_ready, busy, frame_err;
  logic [7:0] rx_data;
`ifdef SPI_SLAVE_OVERRUN_EN
  logic rx_ack = 1'b0;
  logic rx_overrun;
`endif
  int n_cmp = 0, n_bad = 0;
  int rx_cnt = 0, err_cnt = 0, busy_low = 0;
  logic win = 1'b0;
  logic [7:0] rx_log[$];
  logic [7:0] got;
  spi_slave_receiver dut (
    .clk(clk), .reset(reset), .sclk(sclk), .mosi(mosi), .ss(ss), .miso(miso),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data), .tx_load(tx_load),
    .tx_ready(tx_ready), .busy(busy), .frame_err(frame_err)
`ifdef SPI_SLAVE_OVERRUN_EN
    , .rx_ack(rx_ack), .rx_overrun(rx_overrun)
`endif
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (rx_valid) begin
      rx_cnt++;
      rx_log.push_back(rx_data);
    end
    if (frame_err) err_cnt++;
    if (win && !busy) busy_low++;
  end
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  task automatic load(input logic [7:0] v);
    @(negedge clk);
    tx_data = v;
    tx_load = 1'b1;
    @(negedge clk);
    tx_load = 1'b0;
  endtask
  task automatic ss_low;
    ss = 1'b0;
    repeat (4) @(negedge clk);
  endtask
  task automatic ss_high;
    ss = 1'b1;
    repeat (6) @(negedge clk);
  endtask
  task automatic send_bits(input logic [7:0] w, input int n, output logic [7:0] cap);
    cap = '0;
    for (int i = 7; i >= 8 - n; i--) begin
      mosi = w[i];
      repeat (4) @(negedge clk);
      sclk = 1'b1;
      cap = {cap[6:0], miso};
      repeat (4) @(negedge clk);
      sclk = 1'b0;
    end
    repeat (4) @(negedge clk);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    repeat (3) @(negedge clk);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_miso", miso, 0);
    check("rst_rx_data", rx_data, 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    load(8'h3C);
    check("loaded_tx_ready", tx_ready, 0);
    ss_low;
    check("start_tx_ready", tx_ready, 1);
    check("start_busy", busy, 1);
    send_bits(8'hA5, 8, got);
    ss_high;
    check("single_miso", got, 8'h3C);
    check("single_rx_cnt", rx_cnt, 1);
    check("single_rx_data", rx_data, 8'hA5);
    check("single_err", err_cnt, 0);
    check("single_busy_end", busy, 0);
    ss_low;
    send_bits(8'h5A, 8, got);
    ss_high;
    check("noreply_miso", got, 8'h00);
    check("noreply_rx_data", rx_data, 8'h5A);
    rx_log.delete();
    ss_low;
    win = 1'b1;
    send_bits(8'h01, 8, got);
    send_bits(8'hFF, 8, got);
    win = 1'b0;
    ss_high;
    check("b2b_pulses", rx_log.size(), 2);
    if (rx_log.size() == 2) begin
      check("b2b_word0", rx_log[0], 8'h01);
      check("b2b_word1", rx_log[1], 8'hFF);
    end
    check("b2b_busy_gap", busy_low, 0);
    check("b2b_err", err_cnt, 0);
    ss_low;
    send_bits(8'hC3, 5, got);
    ss_high;
    check("abort_err", err_cnt, 1);
    check("abort_rx_cnt", rx_cnt, 4);
    check("abort_rx_data", rx_data, 8'hFF);
    check("abort_busy", busy, 0);
    load(8'h77);
    check("pre_rst_tx_ready", tx_ready, 0);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("async_tx_ready", tx_ready, 1);
    check("async_rx_data", rx_data, 0);
    check("async_busy", busy, 0);
    check("async_rx_valid", rx_valid, 0);
    check("async_frame_err", frame_err, 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
`ifdef SPI_SLAVE_OVERRUN_EN
    check("ovr_reset", rx_overrun, 0);
    ss_low;
    send_bits(8'h11, 8, got);
    check("ovr_first", rx_overrun, 0);
    send_bits(8'h22, 8, got);
    ss_high;
    check("ovr_set", rx_overrun, 1);
    check("ovr_rx_data", rx_data, 8'h22);
    rx_ack = 1'b1;
    @(negedge clk);
    rx_ack = 1'b0;
    @(negedge clk);
    check("ovr_clear", rx_overrun, 0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
